// File: rtl/prog_loader.sv
// Writable 16x8 program memory for the TD4 CPU: loads a program over valid/ready,
// verifies a trailing checksum byte, then releases the CPU and serves instruction bytes.
module prog_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] qd,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StRun, StError} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   mem_q [Depth];
  logic                mem_we;
  logic                accept;
  logic [DATA_W-1:0]   sum_next;

  assign accept   = in_valid && in_ready;
  assign sum_next = sum_q + in_data;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      sum_q   <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      sum_q   <= sum_d;
      if (mem_we) begin
        mem_q[wptr_q] <= in_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    sum_d     = sum_q;
    mem_we    = 1'b0;
    in_ready  = 1'b0;
    cpu_rst_n = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          wptr_d  = '0;
          sum_d   = '0;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          mem_we = 1'b1;
          sum_d  = sum_next;
          wptr_d = wptr_q + 1'b1;
          if (wptr_q == LastAddr) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // A good program plus its checksum byte sums to zero modulo 2**DATA_W.
        if (accept) begin
          state_d = (sum_next == '0) ? StRun : StError;
        end
      end
      StRun: begin
        cpu_rst_n = 1'b1;
        done      = 1'b1;
        if (start) begin
          state_d = StLoad;
          wptr_d  = '0;
          sum_d   = '0;
        end
      end
      StError: begin
        err = 1'b1;
        if (start) begin
          state_d = StLoad;
          wptr_d  = '0;
          sum_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    qd = '0;
    if (state_q == StRun) begin
      qd = mem_q[addr];
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard queues hold expected load outcomes
// and read data, popped and compared when the DUT responds.
module tb_prog_loader;

  localparam int unsigned Depth = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [3:0] addr = 4'h0;
  logic [7:0] qd;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model_mem [Depth];
  logic [7:0] rd_q [$];
  logic [2:0] st_q [$];  // {done, err, cpu_rst_n}

  prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .addr     (addr),
    .qd       (qd),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) step();
    RST = 1'b1;
    for (int i = 0; i < Depth; i++) model_mem[i] = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap, output bit ok);
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic load_prog(input logic [Depth-1:0][7:0] prog, input logic [7:0] chk,
                           input int max_gap, output bit ok);
    bit a;
    logic [7:0] s;
    ok = 1'b1;
    s = 8'h00;
    for (int i = 0; i < Depth; i++) begin
      send_byte(prog[i], $urandom_range(max_gap, 0), a);
      if (a) model_mem[i] = prog[i];
      s = s + prog[i];
      ok = ok & a;
    end
    s = s + chk;
    st_q.push_back((s == 8'h00) ? 3'b101 : 3'b010);
    send_byte(chk, $urandom_range(max_gap, 0), a);
    ok = ok & a;
  endtask

  function automatic logic [Depth-1:0][7:0] ramp(input logic [7:0] base);
    logic [Depth-1:0][7:0] p;
    for (int i = 0; i < Depth; i++) p[i] = base + 8'(i);
    return p;
  endfunction

  function automatic logic [7:0] good_chk(input logic [Depth-1:0][7:0] p);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < Depth; i++) s = s + p[i];
    return 8'h00 - s;
  endfunction

  task automatic test_reset();
    logic [7:0] exp;
    do_reset(2);
    n_checks++;
    if ({in_ready, cpu_rst_n, busy, done, err} !== 5'b00000)
      $display("FAIL reset_outputs: got %b, want 00000", {in_ready, cpu_rst_n, busy, done, err});
    else n_pass++;
    for (int a = 0; a < Depth; a++) begin
      addr = 4'(a);
      rd_q.push_back(8'h00);
      #1;
      exp = rd_q.pop_front();
      n_checks++;
      if (qd !== exp) $display("FAIL reset_qd[%0d]: got %h, want %h", a, qd, exp);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    bit ok;
    logic [2:0] exp_st;
    logic [7:0] exp;
    pulse_start();
    n_checks++;
    if ({busy, in_ready, cpu_rst_n} !== 3'b110)
      $display("FAIL load_entry: got %b, want 110", {busy, in_ready, cpu_rst_n});
    else n_pass++;
    load_prog(ramp(8'h00), 8'h88, 0, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL load_handshake: got %b, want 1", ok);
    else n_pass++;
    exp_st = st_q.pop_front();
    n_checks++;
    if ({done, err, cpu_rst_n} !== exp_st)
      $display("FAIL load_status: got %b, want %b", {done, err, cpu_rst_n}, exp_st);
    else n_pass++;
    n_checks++;
    if ({busy, in_ready} !== 2'b00) $display("FAIL load_idle_bus: got %b, want 00", {busy, in_ready});
    else n_pass++;
    for (int a = 0; a < Depth; a++) begin
      addr = 4'(a);
      rd_q.push_back(model_mem[a]);
      #1;
      exp = rd_q.pop_front();
      n_checks++;
      if (qd !== exp) $display("FAIL load_qd[%0d]: got %h, want %h", a, qd, exp);
      else n_pass++;
    end
  endtask

  task automatic test_bad_checksum();
    bit ok;
    logic [2:0] exp_st;
    logic [7:0] exp;
    pulse_start();
    load_prog(ramp(8'h00), 8'h87, 0, ok);
    exp_st = st_q.pop_front();
    n_checks++;
    if ({done, err, cpu_rst_n} !== exp_st || !ok)
      $display("FAIL bad_status: got %b, want %b", {done, err, cpu_rst_n}, exp_st);
    else n_pass++;
    for (int a = 0; a < Depth; a += 5) begin
      addr = 4'(a);
      rd_q.push_back(8'h00);
      #1;
      exp = rd_q.pop_front();
      n_checks++;
      if (qd !== exp) $display("FAIL bad_qd[%0d]: got %h, want %h", a, qd, exp);
      else n_pass++;
    end
    pulse_start();
    n_checks++;
    if ({err, busy} !== 2'b01) $display("FAIL err_clear: got %b, want 01", {err, busy});
    else n_pass++;
    load_prog(ramp(8'h00), 8'h88, 0, ok);
    exp_st = st_q.pop_front();
    n_checks++;
    if ({done, err, cpu_rst_n} !== exp_st || !ok)
      $display("FAIL recover_status: got %b, want %b", {done, err, cpu_rst_n}, exp_st);
    else n_pass++;
  endtask

  task automatic test_idle_ignore();
    bit ok;
    logic [2:0] exp_st;
    logic [7:0] exp;
    do_reset(2);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL idle_ready[%0d]: got %b, want 0", i, in_ready);
      else n_pass++;
      step();
    end
    in_valid = 1'b0;
    pulse_start();
    load_prog(ramp(8'h00), 8'h88, 3, ok);
    exp_st = st_q.pop_front();
    n_checks++;
    if ({done, err, cpu_rst_n} !== exp_st || !ok)
      $display("FAIL gap_status: got %b, want %b", {done, err, cpu_rst_n}, exp_st);
    else n_pass++;
    for (int a = 0; a < Depth; a++) begin
      addr = 4'(a);
      rd_q.push_back(model_mem[a]);
      #1;
      exp = rd_q.pop_front();
      n_checks++;
      if (qd !== exp) $display("FAIL gap_qd[%0d]: got %h, want %h", a, qd, exp);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    logic [2:0] exp_st;
    logic [7:0] exp;
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i), 0, ok);
    do_reset(1);
    n_checks++;
    if ({busy, in_ready, done, err} !== 4'b0000)
      $display("FAIL midrst_idle: got %b, want 0000", {busy, in_ready, done, err});
    else n_pass++;
    pulse_start();
    load_prog('0, 8'h00, 1, ok);
    exp_st = st_q.pop_front();
    n_checks++;
    if ({done, err, cpu_rst_n} !== exp_st || !ok)
      $display("FAIL zero_status: got %b, want %b", {done, err, cpu_rst_n}, exp_st);
    else n_pass++;
    for (int a = 0; a < Depth; a++) begin
      addr = 4'(a);
      rd_q.push_back(model_mem[a]);
      #1;
      exp = rd_q.pop_front();
      n_checks++;
      if (qd !== exp) $display("FAIL zero_qd[%0d]: got %h, want %h", a, qd, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reload_from_run();
    bit ok;
    logic [2:0] exp_st;
    logic [7:0] exp;
    logic [Depth-1:0][7:0] p;
    p = ramp(8'h30);
    pulse_start();
    n_checks++;
    if ({cpu_rst_n, done, busy} !== 3'b001)
      $display("FAIL reload_entry: got %b, want 001", {cpu_rst_n, done, busy});
    else n_pass++;
    // 30..3F sums to 78, so the zero-sum checksum is 88.
    load_prog(p, good_chk(p), 2, ok);
    exp_st = st_q.pop_front();
    n_checks++;
    if ({done, err, cpu_rst_n} !== exp_st || !ok)
      $display("FAIL reload_status: got %b, want %b", {done, err, cpu_rst_n}, exp_st);
    else n_pass++;
    addr = 4'h2;
    rd_q.push_back(8'h32);
    #1;
    exp = rd_q.pop_front();
    n_checks++;
    if (qd !== exp) $display("FAIL reload_qd2: got %h, want %h", qd, exp);
    else n_pass++;
    for (int a = 0; a < Depth; a++) begin
      addr = 4'(a);
      rd_q.push_back(model_mem[a]);
      #1;
      exp = rd_q.pop_front();
      n_checks++;
      if (qd !== exp) $display("FAIL reload_qd[%0d]: got %h, want %h", a, qd, exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_checksum();
    test_idle_ignore();
    test_mid_reset();
    test_reload_from_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
